// File: rtl/ram_port_sequencer_if.sv
// Bus bundle between the fetch/load-store requesters, the byte-wide RAM and
// the ram_port_sequencer. The sequencer uses the slave view; the environment uses master.
interface ram_port_sequencer_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        f_err;

  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_len;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        ram_rw;
  logic [1:0]  ram_len;
  logic [31:0] ram_addr;
  logic [31:0] ram_write;
  logic [31:0] ram_read;
  logic        ram_exception;

  modport slave (
    input  f_req, f_addr, d_req, d_rw, d_len, d_addr, d_wdata, ram_read, ram_exception,
    output f_gnt, f_done, f_rdata, f_err, d_gnt, d_done, d_rdata, d_err,
           ram_rw, ram_len, ram_addr, ram_write
  );

  modport master (
    output f_req, f_addr, d_req, d_rw, d_len, d_addr, d_wdata, ram_read, ram_exception,
    input  f_gnt, f_done, f_rdata, f_err, d_gnt, d_done, d_rdata, d_err,
           ram_rw, ram_len, ram_addr, ram_write
  );
endinterface

// File: rtl/ram_port_sequencer.sv
// Round-robin sharing of a byte-wide RAM between a word fetch port and a
// byte/half/word load-store port; each access is split into little-endian byte cycles.
module ram_port_sequencer #(
  parameter bit RESP_ZERO_ON_ERR = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_port_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt;
  logic        port_d_r;
  logic        last_d_r;
  logic        rw_r;
  logic [1:0]  len_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  idx_r;
  logic [31:0] acc_r, acc_nxt;
  logic        f_done_r, f_err_r, d_done_r, d_err_r;
  logic [31:0] f_rdata_r, d_rdata_r;

  logic        grant_f_s, grant_d_s, sel_d_s;
  logic        enter_done_s, err_s;
  logic        ram_rw_s;
  logic [31:0] ram_addr_s, ram_write_s, rdata_val_s;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    get_byte = w[7:0];
      2'd1:    get_byte = w[15:8];
      2'd2:    get_byte = w[23:16];
      default: get_byte = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Arbitration, byte sequencing and RAM strobes; everything idles while rst_n is low.
  always_comb begin
    state_nxt    = state_r;
    grant_f_s    = 1'b0;
    grant_d_s    = 1'b0;
    sel_d_s      = port_d_r;
    enter_done_s = 1'b0;
    err_s        = 1'b0;
    acc_nxt      = acc_r;
    ram_rw_s     = 1'b0;
    ram_addr_s   = 32'h0000_0000;
    ram_write_s  = 32'h0000_0000;
    if (!rst_n) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // The port not granted last wins a tie.
          if (bus.f_req && (!bus.d_req || last_d_r)) begin
            grant_f_s = 1'b1;
          end else if (bus.d_req) begin
            grant_d_s = 1'b1;
          end else begin
            grant_f_s = 1'b0;
          end
          if (grant_f_s) begin
            sel_d_s   = 1'b0;
            acc_nxt   = 32'h0000_0000;
            state_nxt = ST_XFER;
          end else if (grant_d_s) begin
            sel_d_s = 1'b1;
            acc_nxt = 32'h0000_0000;
            if (bus.d_len == 2'd3) begin
              state_nxt    = ST_DONE;
              enter_done_s = 1'b1;
              err_s        = 1'b1;
            end else begin
              state_nxt = ST_XFER;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_XFER: begin
          ram_addr_s = addr_r + {30'd0, idx_r};
          if (bus.ram_exception) begin
            err_s        = 1'b1;
            enter_done_s = 1'b1;
            state_nxt    = ST_DONE;
          end else begin
            if (rw_r) begin
              ram_rw_s    = 1'b1;
              ram_write_s = {24'd0, get_byte(wdata_r, idx_r)};
            end else begin
              acc_nxt = put_byte(acc_r, idx_r, bus.ram_read[7:0]);
            end
            if (idx_r == last_idx(len_r)) begin
              enter_done_s = 1'b1;
              state_nxt    = ST_DONE;
            end else begin
              state_nxt = ST_XFER;
            end
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rdata_val_s = (rw_r || (err_s && RESP_ZERO_ON_ERR)) ? 32'h0000_0000 : acc_nxt;

  // State, latched request and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      port_d_r  <= 1'b0;
      last_d_r  <= 1'b1;
      rw_r      <= 1'b0;
      len_r     <= 2'd0;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      idx_r     <= 2'd0;
      acc_r     <= 32'h0000_0000;
      f_done_r  <= 1'b0;
      f_err_r   <= 1'b0;
      f_rdata_r <= 32'h0000_0000;
      d_done_r  <= 1'b0;
      d_err_r   <= 1'b0;
      d_rdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt;
      acc_r   <= acc_nxt;
      if (grant_f_s || grant_d_s) begin
        port_d_r <= grant_d_s;
        last_d_r <= grant_d_s;
        rw_r     <= grant_d_s & bus.d_rw;
        len_r    <= grant_d_s ? bus.d_len : 2'd2;
        addr_r   <= grant_d_s ? bus.d_addr : bus.f_addr;
        wdata_r  <= grant_d_s ? bus.d_wdata : 32'h0000_0000;
        idx_r    <= 2'd0;
      end else if (state_r == ST_XFER) begin
        idx_r <= idx_r + 2'd1;
      end else begin
        idx_r <= idx_r;
      end
      f_done_r <= enter_done_s & ~sel_d_s;
      f_err_r  <= enter_done_s & ~sel_d_s & err_s;
      d_done_r <= enter_done_s & sel_d_s;
      d_err_r  <= enter_done_s & sel_d_s & err_s;
      if (enter_done_s && !sel_d_s) begin
        f_rdata_r <= rdata_val_s;
      end else begin
        f_rdata_r <= f_rdata_r;
      end
      if (enter_done_s && sel_d_s) begin
        d_rdata_r <= rdata_val_s;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  assign bus.f_gnt     = grant_f_s;
  assign bus.d_gnt     = grant_d_s;
  assign bus.f_done    = f_done_r;
  assign bus.f_err     = f_err_r;
  assign bus.f_rdata   = f_rdata_r;
  assign bus.d_done    = d_done_r;
  assign bus.d_err     = d_err_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.ram_rw    = ram_rw_s;
  assign bus.ram_len   = 2'b00;
  assign bus.ram_addr  = ram_addr_s;
  assign bus.ram_write = ram_write_s;

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Scoreboard bench for ram_port_sequencer: directed requests push expected
// responses; a monitor pops and compares on every done pulse.
module tb_ram_port_sequencer;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_done_cyc = 0;

  ram_port_sequencer_if bus ();

  ram_port_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } resp_t;
  resp_t exp_q[$];

  // RAM model: 8 KiB, out-of-range from 0x2000, plus a backdoor preload port
  logic [7:0]  mem [0:8191];
  logic        pre_we = 1'b0;
  logic [12:0] pre_a = 13'd0;
  logic [7:0]  pre_d = 8'd0;
  logic [31:0] wlog_addr[$];
  logic [7:0]  wlog_data[$];
  int          bad_addr = 0;
  int          bad_wr = 0;
  int          act_cnt = 0;

  assign bus.ram_exception = (bus.ram_addr >= 32'h0000_2000);
  assign bus.ram_read      = {24'd0, mem[bus.ram_addr[12:0]]};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    if (bus.ram_addr == 32'h0000_2001) bad_addr <= bad_addr + 1;
    if (bus.ram_rw && (bus.ram_exception || bus.ram_write[31:8] != 24'd0)) bad_wr <= bad_wr + 1;
    if (bus.ram_rw || bus.ram_addr != 32'h0) act_cnt <= act_cnt + 1;
    if (bus.ram_rw && !bus.ram_exception) begin
      mem[bus.ram_addr[12:0]] <= bus.ram_write[7:0];
      wlog_addr.push_back(bus.ram_addr);
      wlog_data.push_back(bus.ram_write[7:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected response
  always @(negedge clk) begin
    if (bus.f_done || bus.d_done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got f_done=%0d d_done=%0d expected none", bus.f_done, bus.d_done);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("done_port", {30'd0, bus.d_done, bus.f_done}, e.port_d ? 32'd2 : 32'd1);
        chk("rdata", e.port_d ? bus.d_rdata : bus.f_rdata, e.rdata);
        chk("err", {31'd0, e.port_d ? bus.d_err : bus.f_err}, {31'd0, e.err});
      end
    end
  end

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic expect_resp(input bit port_d, input logic [31:0] rdata, input bit err);
    resp_t e;
    e.port_d = port_d; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit is_d, input bit rw, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata, output int gcyc);
    @(negedge clk);
    bus.f_req = !is_d; bus.f_addr = addr;
    bus.d_req = is_d;  bus.d_rw = rw; bus.d_len = len; bus.d_addr = addr; bus.d_wdata = wdata;
    gcyc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (is_d ? bus.d_gnt : bus.f_gnt) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (gcyc < 0) begin
      checks++; failures++;
      $display("FAIL gnt_timeout: got no grant expected grant within 20 cycles");
    end else begin
      chk("single_gnt", {31'd0, bus.f_gnt & bus.d_gnt}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    bus.f_addr = 32'hFFFF_FFF0; bus.d_addr = 32'hFFFF_FFF0;
    bus.d_wdata = 32'h0000_0000; bus.d_len = 2'd2; bus.d_rw = !rw;
  endtask

  task automatic wait_done(input string name, input int gcyc, input int lat);
    int got;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (bus.f_done || bus.d_done) begin
        got = cyc;
        break;
      end
    end
    if (got < 0) begin
      checks++; failures++;
      $display("FAIL %s: got no done expected done within 20 cycles", name);
    end else begin
      chk(name, got - gcyc, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int k;
    int gl;
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_len = 2'd0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    rst_n = 1'b0;
    preload(13'h010, 8'h11); preload(13'h011, 8'h22);
    preload(13'h012, 8'h33); preload(13'h013, 8'h44);
    preload(13'h1FFE, 8'hA5); preload(13'h1FFF, 8'h5A);
    for (int i = 0; i < 4; i++) preload(13'h040 + 13'(i), 8'h00);

    // Reset state, with requests pending
    @(negedge clk);
    bus.f_req = 1'b1; bus.d_req = 1'b1; bus.f_addr = 32'h10; bus.d_addr = 32'h20;
    #1;
    chk("rst_gnt", {30'd0, bus.f_gnt, bus.d_gnt}, 32'd0);
    chk("rst_done", {30'd0, bus.f_done, bus.d_done}, 32'd0);
    chk("rst_rdata", bus.f_rdata | bus.d_rdata, 32'd0);
    chk("rst_ram", {31'd0, bus.ram_rw} | bus.ram_addr | bus.ram_write, 32'd0);
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fetch word at 0x10
    expect_resp(1'b0, 32'h4433_2211, 1'b0);
    issue(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, g);
    wait_done("t1_latency", g, 5);

    // 2: half write 0xBEEF at 0x20, then read back
    wlog_addr.delete(); wlog_data.delete();
    expect_resp(1'b1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 2'd1, 32'h20, 32'h1234_BEEF, g);
    wait_done("t2_wr_latency", g, 3);
    chk("t2_wr_count", wlog_addr.size(), 32'd2);
    if (wlog_addr.size() == 2) begin
      chk("t2_wr0_addr", wlog_addr[0], 32'h20);
      chk("t2_wr0_data", {24'd0, wlog_data[0]}, 32'hEF);
      chk("t2_wr1_addr", wlog_addr[1], 32'h21);
      chk("t2_wr1_data", {24'd0, wlog_data[1]}, 32'hBE);
    end
    expect_resp(1'b1, 32'h0000_BEEF, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 32'h20, 32'h0, g);
    wait_done("t2_rd_latency", g, 3);

    // 3: both ports held high from reset -> F,D,F,D
    @(negedge clk);
    rst_n = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_len = 2'd0; bus.d_addr = 32'h21;
    expect_resp(1'b0, 32'h4433_2211, 1'b0);
    expect_resp(1'b1, 32'h0000_00BE, 1'b0);
    expect_resp(1'b0, 32'h4433_2211, 1'b0);
    expect_resp(1'b1, 32'h0000_00BE, 1'b0);
    @(negedge clk);
    #1;
    chk("t3_rst_gnt", {30'd0, bus.f_gnt, bus.d_gnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; gl = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      #1;
      if (bus.f_gnt || bus.d_gnt) begin
        chk("t3_order", {31'd0, bus.d_gnt}, 32'(k % 2));
        if (k > 0) chk("t3_gap", cyc - last_done_cyc, 32'd1);
        gl = cyc;
        k++;
        if (k == 4) begin
          @(posedge clk);
          #1;
          bus.f_req = 1'b0; bus.d_req = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("t3_grants", k, 32'd4);
    wait_done("t3_last_latency", gl, 2);

    // 4: word read straddling the 0x2000 limit
    bad_addr = 0; bad_wr = 0;
    expect_resp(1'b1, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 32'h1FFE, 32'h0, g);
    wait_done("t4_latency", g, 4);
    chk("t4_no_0x2001", bad_addr, 32'd0);
    chk("t4_no_bad_wr", bad_wr, 32'd0);

    // 5: illegal length
    act_cnt = 0;
    expect_resp(1'b1, 32'h0, 1'b1);
    issue(1'b1, 1'b1, 2'd3, 32'h30, 32'hCAFE_F00D, g);
    wait_done("t5_latency", g, 1);
    chk("t5_no_ram_activity", act_cnt, 32'd0);

    // 6: reset during byte 1 of a word write
    wlog_addr.delete(); wlog_data.delete();
    issue(1'b1, 1'b1, 2'd2, 32'h40, 32'hDDCC_BBAA, g);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rw_in_reset", {31'd0, bus.ram_rw}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_wr_count", wlog_addr.size(), 32'd1);
    chk("t6_mem40", {24'd0, mem[13'h040]}, 32'hAA);
    chk("t6_mem41", {24'd0, mem[13'h041]}, 32'h00);
    expect_resp(1'b0, 32'h0000_00AA, 1'b0);
    issue(1'b0, 1'b0, 2'd2, 32'h40, 32'h0, g);
    wait_done("t6_after_latency", g, 5);

    repeat (3) @(negedge clk);
    chk("ram_len", {30'd0, bus.ram_len}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
